// File: rtl/pipe_stall_ctrl_if.sv
// Handshake bundle between the pipeline stages and the stall/flush sequencer.
// The pipeline side is the master; the sequencer is the slave.
interface pipe_stall_ctrl_if #(
    parameter int LEN_W = 4,
    parameter int CNT_W = 16
);
    logic             stallreq_id;
    logic             ex_mc_start;
    logic [LEN_W-1:0] ex_mc_len;
    logic             flush_req;
    logic             stat_clr;
    logic [5:0]       stall;
    logic             flush;
    logic             busy;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output stallreq_id, ex_mc_start, ex_mc_len, flush_req, stat_clr,
        input  stall, flush, busy, stall_cnt
    );

    modport slave (
        input  stallreq_id, ex_mc_start, ex_mc_len, flush_req, stat_clr,
        output stall, flush, busy, stall_cnt
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: sequences multi-cycle ex ops,
// load-use bubbles and exception flushes, and counts stalled cycles for perf monitoring.
module pipe_stall_ctrl #(
    parameter int LEN_W     = 4,
    parameter int FLUSH_LEN = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    pipe_stall_ctrl_if.slave bus
);
    localparam int FL_W  = $clog2(FLUSH_LEN + 1);
    localparam int CTR_W = (LEN_W > FL_W) ? LEN_W : FL_W;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_LU   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_EX_WAIT = 2'd1,
        ST_FLUSH   = 2'd2
    } state_e;

    state_e             state_r;
    state_e             state_s;
    logic [CTR_W-1:0]   ctr_r;
    logic [CTR_W-1:0]   ctr_s;
    logic [5:0]         stall_s;
    logic [LEN_W-1:0]   eff_len_s;
    logic [CNT_W-1:0]   stall_cnt_r;

    // A zero-length op still occupies ex for one cycle.
    assign eff_len_s = (bus.ex_mc_len == {LEN_W{1'b0}}) ? {{(LEN_W-1){1'b0}}, 1'b1}
                                                         : bus.ex_mc_len;

    // State and remaining-cycle counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_RUN;
            ctr_r   <= {CTR_W{1'b0}};
        end else begin
            state_r <= state_s;
            ctr_r   <= ctr_s;
        end
    end

    // Next-state, counter and stall vector; flush_req outranks everything, then ex, then load-use.
    always_comb begin
        state_s = state_r;
        ctr_s   = ctr_r;
        stall_s = STALL_NONE;
        case (state_r)
            ST_RUN: begin
                if (bus.flush_req) begin
                    state_s = ST_FLUSH;
                    ctr_s   = CTR_W'(FLUSH_LEN - 1);
                end else if (bus.ex_mc_start) begin
                    stall_s = STALL_EX;
                    if (eff_len_s > {{(LEN_W-1){1'b0}}, 1'b1}) begin
                        state_s = ST_EX_WAIT;
                        ctr_s   = CTR_W'(eff_len_s - LEN_W'(2));
                    end else begin
                        state_s = ST_RUN;
                    end
                end else if (bus.stallreq_id) begin
                    stall_s = STALL_LU;
                end else begin
                    stall_s = STALL_NONE;
                end
            end
            ST_EX_WAIT: begin
                if (bus.flush_req) begin
                    state_s = ST_FLUSH;
                    ctr_s   = CTR_W'(FLUSH_LEN - 1);
                end else begin
                    // A second start here is a protocol error and is simply not looked at.
                    stall_s = STALL_EX;
                    if (ctr_r == {CTR_W{1'b0}}) begin
                        state_s = ST_RUN;
                    end else begin
                        ctr_s = ctr_r - CTR_W'(1);
                    end
                end
            end
            ST_FLUSH: begin
                if (bus.flush_req) begin
                    ctr_s = CTR_W'(FLUSH_LEN - 1);
                end else if (ctr_r == {CTR_W{1'b0}}) begin
                    state_s = ST_RUN;
                end else begin
                    ctr_s = ctr_r - CTR_W'(1);
                end
            end
            default: begin
                state_s = ST_RUN;
                ctr_s   = {CTR_W{1'b0}};
            end
        endcase
    end

    // Saturating stalled-cycle counter; clear beats increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (bus.stat_clr) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if ((stall_s != STALL_NONE) && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end
    end

    assign bus.stall     = stall_s;
    assign bus.flush     = (state_r == ST_FLUSH);
    assign bus.busy      = (state_r == ST_EX_WAIT) || (state_r == ST_FLUSH);
    assign bus.stall_cnt = stall_cnt_r;
endmodule
